// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op encodings and the ID/EX
// pipeline record with its all-zero bubble.
package cpu_pkg;
  localparam int DW = 32;
  localparam int RW = 5;

  typedef enum logic [3:0] {
    ALUC_ADD = 4'b0000,
    ALUC_SUB = 4'b0100,
    ALUC_AND = 4'b0001,
    ALUC_OR  = 4'b0101,
    ALUC_XOR = 4'b0010,
    ALUC_LUI = 4'b0110,
    ALUC_SLL = 4'b0011,
    ALUC_SRL = 4'b0111,
    ALUC_SRA = 4'b1111,
    ALUC_MAX = 4'b1011,
    ALUC_HAM = 4'b1010
  } aluc_e;

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic          aluimm;
    logic          shift;
    logic          jal;
    logic [3:0]    aluc;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rn;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
  } idex_t;

  // A bubble is a fully zeroed record: invalid, no writes, ALU op ADD.
  localparam idex_t BUBBLE = '0;
endpackage

// File: rtl/idex_stage_fwd_sel.sv
// One operand's forwarding select: MEM result beats WB result beats the
// register-file value; register 0 never forwards.
module fwd_sel import cpu_pkg::*; (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] rf_val,
  input  logic          m_wreg,
  input  logic [RW-1:0] m_rn,
  input  logic [DW-1:0] m_alu,
  input  logic          w_wreg,
  input  logic [RW-1:0] w_rn,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] val
);
  logic m_hit, w_hit;

  assign m_hit = m_wreg && (m_rn != '0) && (m_rn == src);
  assign w_hit = w_wreg && (w_rn != '0) && (w_rn == src);
  assign val   = m_hit ? m_alu : (w_hit ? w_data : rf_val);
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall
// detection, bubble injection on stall or flush, and a saturating stall counter.
module idex_stage import cpu_pkg::*; #(
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          d_valid,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_jal,
  input  logic [3:0]    d_aluc,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic [RW-1:0] d_rn,
  input  logic [DW-1:0] d_qa,
  input  logic [DW-1:0] d_qb,
  input  logic [DW-1:0] d_imm,
  input  logic [DW-1:0] d_pc4,
  input  logic          flush,
  input  logic          m_wreg,
  input  logic [RW-1:0] m_rn,
  input  logic [DW-1:0] m_alu,
  input  logic          w_wreg,
  input  logic [RW-1:0] w_rn,
  input  logic [DW-1:0] w_data,
  output logic          hazard_stall,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_aluc,
  output logic          e_valid,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          e_jal,
  output logic [RW-1:0] e_rn,
  output logic [DW-1:0] e_store,
  output logic [DW-1:0] e_pc8,
  output logic [15:0]   stall_cnt
);
  idex_t         ex, d, nxt;
  logic          raw;
  logic [DW-1:0] fwd_a, fwd_b;

  assign d = '{valid: d_valid, wreg: d_wreg, m2reg: d_m2reg, wmem: d_wmem,
               aluimm: d_aluimm, shift: d_shift, jal: d_jal, aluc: d_aluc,
               rs: d_rs, rt: d_rt, rn: d_rn, qa: d_qa, qb: d_qb,
               imm: d_imm, pc4: d_pc4};

  // Both sources are compared even when the instruction only reads one.
  assign raw = ex.valid && ex.m2reg && (ex.rn != '0) && d_valid &&
               ((d_rs == ex.rn) || (d_rt == ex.rn));
  assign hazard_stall = raw & ~flush;

  always_comb begin
    nxt = d;
    if (flush || raw) nxt = BUBBLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ex <= BUBBLE;
    else       ex <= nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    stall_cnt <= '0;
    else if (hazard_stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 16'd1;
  end

  fwd_sel u_fwd_rs (
    .src(ex.rs), .rf_val(ex.qa),
    .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .val(fwd_a)
  );

  fwd_sel u_fwd_rt (
    .src(ex.rt), .rf_val(ex.qb),
    .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .val(fwd_b)
  );

  // Shift amount lives in the sa field, imm[10:6].
  assign alu_a    = ex.shift  ? {{(DW-5){1'b0}}, ex.imm[10:6]} : fwd_a;
  assign alu_b    = ex.aluimm ? ex.imm : fwd_b;
  assign alu_aluc = ex.aluc;
  assign e_valid  = ex.valid;
  assign e_wreg   = ex.wreg;
  assign e_m2reg  = ex.m2reg;
  assign e_wmem   = ex.wmem;
  assign e_jal    = ex.jal;
  assign e_rn     = ex.rn;
  assign e_store  = fwd_b;
  assign e_pc8    = ex.pc4 + DW'(4);
endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed vector table, reset corner sequences, then
// random traffic against a behavioural model of the stage.
module tb_idex_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
  logic [3:0]  d_aluc;
  logic [4:0]  d_rs, d_rt, d_rn;
  logic [31:0] d_qa, d_qb, d_imm, d_pc4;
  logic        flush, m_wreg, w_wreg;
  logic [4:0]  m_rn, w_rn;
  logic [31:0] m_alu, w_data;

  logic        hazard_stall, e_valid, e_wreg, e_m2reg, e_wmem, e_jal;
  logic [31:0] alu_a, alu_b, e_store, e_pc8;
  logic [3:0]  alu_aluc;
  logic [4:0]  e_rn;
  logic [15:0] stall_cnt;

  logic        s_hazard_stall, s_e_valid, s_e_wreg, s_e_m2reg, s_e_wmem, s_e_jal;
  logic [31:0] s_alu_a, s_alu_b, s_e_store, s_e_pc8;
  logic [3:0]  s_alu_aluc;
  logic [4:0]  s_e_rn;
  logic [15:0] s_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  idex_stage dut (
    .clock(clock), .reset(reset),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
    .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_pc4(d_pc4),
    .flush(flush), .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .hazard_stall(hazard_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_jal(e_jal), .e_rn(e_rn), .e_store(e_store), .e_pc8(e_pc8),
    .stall_cnt(stall_cnt)
  );

  // Second copy with a tiny saturation ceiling so the clamp is reachable.
  idex_stage #(.CNT_MAX(16'd3)) dut_sat (
    .clock(clock), .reset(reset),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
    .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_pc4(d_pc4),
    .flush(flush), .m_wreg(m_wreg), .m_rn(m_rn), .m_alu(m_alu),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .hazard_stall(s_hazard_stall), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_aluc(s_alu_aluc),
    .e_valid(s_e_valid), .e_wreg(s_e_wreg), .e_m2reg(s_e_m2reg), .e_wmem(s_e_wmem),
    .e_jal(s_e_jal), .e_rn(s_e_rn), .e_store(s_e_store), .e_pc8(s_e_pc8),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic dv, dwreg, dm2reg, dwmem, daluimm, dshift, djal;
    logic [3:0]  daluc;
    logic [4:0]  drs, drt, drn;
    logic [31:0] dqa, dqb, dimm, dpc4;
    logic        fl, mw;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic        ww;
    logic [4:0]  wrn;
    logic [31:0] wdata;
    logic        hz;
    logic [31:0] a, b, st;
    logic [3:0]  aluc;
    logic        ev, ewreg, em2reg, ewmem, ejal;
    logic [4:0]  ern;
    logic [31:0] pc8;
    logic [15:0] cnt, cnts;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    d_valid = v.dv; d_wreg = v.dwreg; d_m2reg = v.dm2reg; d_wmem = v.dwmem;
    d_aluimm = v.daluimm; d_shift = v.dshift; d_jal = v.djal; d_aluc = v.daluc;
    d_rs = v.drs; d_rt = v.drt; d_rn = v.drn;
    d_qa = v.dqa; d_qb = v.dqb; d_imm = v.dimm; d_pc4 = v.dpc4;
    flush = v.fl; m_wreg = v.mw; m_rn = v.mrn; m_alu = v.malu;
    w_wreg = v.ww; w_rn = v.wrn; w_data = v.wdata;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, " hazard_stall"}, 32'(hazard_stall), 32'(v.hz));
    chk({tag, " alu_a"}, alu_a, v.a);
    chk({tag, " alu_b"}, alu_b, v.b);
    chk({tag, " e_store"}, e_store, v.st);
    chk({tag, " alu_aluc"}, 32'(alu_aluc), 32'(v.aluc));
    chk({tag, " e_valid"}, 32'(e_valid), 32'(v.ev));
    chk({tag, " e_wreg"}, 32'(e_wreg), 32'(v.ewreg));
    chk({tag, " e_m2reg"}, 32'(e_m2reg), 32'(v.em2reg));
    chk({tag, " e_wmem"}, 32'(e_wmem), 32'(v.ewmem));
    chk({tag, " e_jal"}, 32'(e_jal), 32'(v.ejal));
    chk({tag, " e_rn"}, 32'(e_rn), 32'(v.ern));
    chk({tag, " e_pc8"}, e_pc8, v.pc8);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(v.cnt));
    chk({tag, " sat stall_cnt"}, 32'(s_stall_cnt), 32'(v.cnts));
  endtask

  // Reference forwarding: newest producer (MEM) wins, r0 is hardwired.
  function automatic logic [31:0] fwd(input vec_t v, input logic [4:0] r, input logic [31:0] q);
    if (r == 5'd0) return q;
    if (v.mw && v.mrn == r) return v.malu;
    if (v.ww && v.wrn == r) return v.wdata;
    return q;
  endfunction

  vec_t tbl [11];
  vec_t v, mex;
  int   mcnt, mcnts;
  logic raw_m;

  initial begin
    // Directed table: inputs applied in a cycle, expectations for that cycle.
    for (int i = 0; i < 11; i++) tbl[i] = '0;
    tbl[0].dv = 1; tbl[0].dwreg = 1; tbl[0].drs = 5; tbl[0].drn = 3; tbl[0].dqa = 32'hAAAA; tbl[0].dpc4 = 32'h100;
    tbl[0].pc8 = 32'h4;
    tbl[1] = tbl[0]; tbl[1].mw = 1; tbl[1].mrn = 5; tbl[1].malu = 32'h11; tbl[1].ww = 1; tbl[1].wrn = 5; tbl[1].wdata = 32'h22;
    tbl[1].a = 32'h11; tbl[1].ev = 1; tbl[1].ewreg = 1; tbl[1].ern = 3; tbl[1].pc8 = 32'h104;
    tbl[2].dv = 1; tbl[2].dwreg = 1; tbl[2].dm2reg = 1; tbl[2].daluimm = 1; tbl[2].drn = 8; tbl[2].dimm = 32'h4; tbl[2].dpc4 = 32'h104;
    tbl[2].mw = 1; tbl[2].mrn = 0; tbl[2].malu = 32'hFFFF; tbl[2].ww = 1; tbl[2].wrn = 5; tbl[2].wdata = 32'h22;
    tbl[2].a = 32'h22; tbl[2].ev = 1; tbl[2].ewreg = 1; tbl[2].ern = 3; tbl[2].pc8 = 32'h104;
    tbl[3].dv = 1; tbl[3].dwreg = 1; tbl[3].daluimm = 1; tbl[3].drs = 8; tbl[3].drt = 9; tbl[3].drn = 10; tbl[3].dqa = 32'h1234; tbl[3].dimm = 32'h10; tbl[3].dpc4 = 32'h108;
    tbl[3].hz = 1; tbl[3].b = 32'h4; tbl[3].ev = 1; tbl[3].ewreg = 1; tbl[3].em2reg = 1; tbl[3].ern = 8; tbl[3].pc8 = 32'h108;
    tbl[4] = tbl[3]; tbl[4].ww = 1; tbl[4].wrn = 8; tbl[4].wdata = 32'h5555;
    tbl[4].hz = 0; tbl[4].b = 0; tbl[4].ev = 0; tbl[4].ewreg = 0; tbl[4].em2reg = 0; tbl[4].ern = 0; tbl[4].pc8 = 32'h4; tbl[4].cnt = 1; tbl[4].cnts = 1;
    tbl[5].dv = 1; tbl[5].dwreg = 1; tbl[5].dshift = 1; tbl[5].daluc = 4'b0011; tbl[5].drn = 2; tbl[5].dimm = 32'h7C0; tbl[5].dpc4 = 32'h10C;
    tbl[5].ww = 1; tbl[5].wrn = 8; tbl[5].wdata = 32'h5555;
    tbl[5].a = 32'h5555; tbl[5].b = 32'h10; tbl[5].ev = 1; tbl[5].ewreg = 1; tbl[5].ern = 10; tbl[5].pc8 = 32'h10C; tbl[5].cnt = 1; tbl[5].cnts = 1;
    tbl[6].dv = 1; tbl[6].dwreg = 1; tbl[6].dm2reg = 1; tbl[6].daluimm = 1; tbl[6].drn = 7; tbl[6].dpc4 = 32'h110;
    tbl[6].a = 32'h1F; tbl[6].aluc = 4'b0011; tbl[6].ev = 1; tbl[6].ewreg = 1; tbl[6].ern = 2; tbl[6].pc8 = 32'h110; tbl[6].cnt = 1; tbl[6].cnts = 1;
    tbl[7].dv = 1; tbl[7].dwreg = 1; tbl[7].dwmem = 1; tbl[7].drs = 1; tbl[7].drt = 7; tbl[7].drn = 4; tbl[7].dpc4 = 32'h114; tbl[7].fl = 1;
    tbl[7].ev = 1; tbl[7].ewreg = 1; tbl[7].em2reg = 1; tbl[7].ern = 7; tbl[7].pc8 = 32'h114; tbl[7].cnt = 1; tbl[7].cnts = 1;
    tbl[8].dv = 1; tbl[8].dpc4 = 32'hFFFF_FFFC;
    tbl[8].pc8 = 32'h4; tbl[8].cnt = 1; tbl[8].cnts = 1;
    tbl[9].ev = 1; tbl[9].pc8 = 32'h0; tbl[9].cnt = 1; tbl[9].cnts = 1;
    tbl[10].pc8 = 32'h4; tbl[10].cnt = 1; tbl[10].cnts = 1;

    v = '0;
    apply(v);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      #3;
      check_vec(tbl[i], $sformatf("row%0d", i));
      @(posedge clock); #1;
    end

    // Reset in the middle of a stall cycle, with live non-zero inputs.
    v = '0; v.dv = 1; v.dwreg = 1; v.dm2reg = 1; v.drn = 8; v.daluc = 4'b0101; v.dpc4 = 32'h200;
    apply(v);
    @(posedge clock); #1;
    v = '0; v.dv = 1; v.dwreg = 1; v.drs = 8; v.drn = 10; v.dpc4 = 32'h204; v.mw = 1; v.malu = 32'hFFFF;
    apply(v);
    #1;
    chk("pre-reset hazard_stall", 32'(hazard_stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset hazard_stall", 32'(hazard_stall), 32'd0);
    chk("async reset e_valid", 32'(e_valid), 32'd0);
    chk("async reset alu_aluc", 32'(alu_aluc), 32'd0);
    chk("async reset e_pc8", e_pc8, 32'd4);
    chk("async reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async reset alu_a", alu_a, 32'd0);
    chk("async reset alu_b", alu_b, 32'd0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    chk("post-reset e_valid", 32'(e_valid), 32'd1);
    chk("post-reset e_rn", 32'(e_rn), 32'd10);
    chk("post-reset stall_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic against the model; small register space keeps hazards common.
    reset = 1'b1;
    #1 reset = 1'b0;
    mex = '0; mcnt = 0; mcnts = 0;
    for (int i = 0; i < 400; i++) begin
      v = '0;
      v.dv = ($urandom_range(0, 3) != 0);
      v.dwreg = 1'($urandom); v.dm2reg = ($urandom_range(0, 1) == 0); v.dwmem = 1'($urandom);
      v.daluimm = 1'($urandom); v.dshift = ($urandom_range(0, 3) == 0); v.djal = 1'($urandom);
      v.daluc = 4'($urandom);
      v.drs = 5'($urandom_range(0, 3)); v.drt = 5'($urandom_range(0, 3)); v.drn = 5'($urandom_range(0, 3));
      v.dqa = $urandom; v.dqb = $urandom; v.dimm = $urandom;
      v.dpc4 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      v.fl = ($urandom_range(0, 7) == 0);
      v.mw = 1'($urandom); v.mrn = 5'($urandom_range(0, 3)); v.malu = $urandom;
      v.ww = 1'($urandom); v.wrn = 5'($urandom_range(0, 3)); v.wdata = $urandom;
      apply(v);

      raw_m = mex.dv && mex.dm2reg && (mex.drn != 0) && v.dv &&
              (v.drs == mex.drn || v.drt == mex.drn);
      v.hz     = raw_m && !v.fl;
      v.a      = mex.dshift ? ((mex.dimm >> 6) & 32'd31) : fwd(v, mex.drs, mex.dqa);
      v.st     = fwd(v, mex.drt, mex.dqb);
      v.b      = mex.daluimm ? mex.dimm : v.st;
      v.aluc   = mex.daluc;
      v.ev     = mex.dv;  v.ewreg = mex.dwreg; v.em2reg = mex.dm2reg;
      v.ewmem  = mex.dwmem; v.ejal = mex.djal; v.ern = mex.drn;
      v.pc8    = mex.dpc4 + 32'd4;
      v.cnt    = 16'(mcnt);
      v.cnts   = 16'(mcnts);
      #2;
      check_vec(v, $sformatf("rand%0d", i));

      if (v.hz) begin
        if (mcnt < 65535) mcnt++;
        if (mcnts < 3) mcnts++;
      end
      mex = (v.fl || raw_m) ? '0 : v;
      @(posedge clock); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
